clause_bin_loader: RTL

CLAUSE_BIN_LOADER -- requirements
Module: clause_bin_loader

---
 rtl/sat_pkg.sv | 23 ++
 rtl/clause_bin_loader_if.sv | 30 +++
 rtl/lit_sanitize.sv | 22 ++
 rtl/clause_bin_loader.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// Shared types for the clause-bin loader: FSM states and 2-bit literal codes.
// The literal cleaning rule lives here so that every user applies the same one.
package sat_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    LOAD_FLUSH = 3'd2,
    STORE      = 3'd3,
    DONE       = 3'd4
  } state_t;

  localparam logic [1:0] LIT_NONE = 2'b00;
  localparam logic [1:0] LIT_NEG  = 2'b01;
  localparam logic [1:0] LIT_POS  = 2'b10;
  localparam logic [1:0] LIT_BAD  = 2'b11;

  // An illegal code is turned into "absent" so that it never reaches the array.
  function automatic logic [1:0] clean_lit(input logic [1:0] code);
    return (code == LIT_BAD) ? LIT_NONE : code;
  endfunction

endpackage

// File: rtl/clause_bin_loader_if.sv
// Bin memory port of the clause-bin loader: one read strobe with 1-cycle latency
// and one write strobe, sharing a single address bus.
interface clause_bin_loader_if #(
  parameter int NUM_LITS = 8,
  parameter int ADDR_W   = 10
);

  logic                  mem_rd_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [NUM_LITS*2-1:0] mem_rdata_i;
  logic                  mem_wr_o;
  logic [NUM_LITS*2-1:0] mem_wdata_o;

  modport master (
    output mem_rd_o,
    output mem_addr_o,
    output mem_wr_o,
    output mem_wdata_o,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_rd_o,
    input  mem_addr_o,
    input  mem_wr_o,
    input  mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/lit_sanitize.sv
// Combinational cleaner for one clause word: illegal literal fields become
// "absent", and a flag reports whether any were found.
module lit_sanitize
  import sat_pkg::*;
#(
  parameter int NUM_LITS = 8
) (
  input  logic [NUM_LITS*2-1:0] raw,
  output logic [NUM_LITS*2-1:0] clean,
  output logic                  bad
);

  logic [NUM_LITS-1:0] bad_vec;

  for (genvar gi = 0; gi < NUM_LITS; gi++) begin : g_lit
    assign clean[gi*2 +: 2] = clean_lit(raw[gi*2 +: 2]);
    assign bad_vec[gi]      = (raw[gi*2 +: 2] == LIT_BAD);
  end

  assign bad = |bad_vec;

endmodule

// File: rtl/clause_bin_loader.sv
// Copies a bin of clause rows between the bin memory and the clause engine array,
// one row per cycle, in either direction.
module clause_bin_loader
  import sat_pkg::*;
#(
  parameter int NUM_LITS    = 8,
  parameter int NUM_CLAUSES = 8,
  parameter int ADDR_W      = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_load_i,
  input  logic                              start_store_i,
  input  logic [ADDR_W-1:0]                 base_addr_i,
  clause_bin_loader_if.master               mem,
  output logic [NUM_CLAUSES-1:0]            wr_o,
  output logic [NUM_LITS*2-1:0]             lit_o,
  input  logic [NUM_CLAUSES*NUM_LITS*2-1:0] lits_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              err_o
);

  localparam int W     = NUM_LITS * 2;
  localparam int IDX_W = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLAUSES - 1);

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic              wr_pend_reg, wr_pend_next;
  logic [IDX_W-1:0]  wr_idx_reg, wr_idx_next;
  logic              err_reg, err_next;

  logic [W-1:0]      rows [NUM_CLAUSES];
  logic [W-1:0]      clean_word;
  logic              clean_bad;

  // Row 0 sits in the most significant slice of the readback bus.
  for (genvar gi = 0; gi < NUM_CLAUSES; gi++) begin : g_row
    assign rows[gi] = lits_i[(NUM_CLAUSES-1-gi)*W +: W];
  end

  lit_sanitize #(
    .NUM_LITS (NUM_LITS)
  ) u_sanitize (
    .raw   (mem.mem_rdata_i),
    .clean (clean_word),
    .bad   (clean_bad)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      base_reg    <= '0;
      wr_pend_reg <= 1'b0;
      wr_idx_reg  <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      base_reg    <= base_next;
      wr_pend_reg <= wr_pend_next;
      wr_idx_reg  <= wr_idx_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    base_next       = base_reg;
    wr_pend_next    = 1'b0;
    wr_idx_next     = idx_reg;
    err_next        = err_reg;
    mem.mem_rd_o    = 1'b0;
    mem.mem_wr_o    = 1'b0;
    mem.mem_addr_o  = '0;
    mem.mem_wdata_o = '0;
    busy_o          = 1'b0;
    done_o          = 1'b0;

    // Read data of the previous cycle is being written into the array now.
    if (wr_pend_reg && clean_bad) begin
      err_next = 1'b1;
    end

    unique case (state_reg)
      IDLE: begin
        if (start_load_i) begin
          state_next = LOAD;
          idx_next   = '0;
          base_next  = base_addr_i;
          err_next   = 1'b0;
        end else if (start_store_i) begin
          state_next = STORE;
          idx_next   = '0;
          base_next  = base_addr_i;
        end
      end
      LOAD: begin
        busy_o         = 1'b1;
        mem.mem_rd_o   = 1'b1;
        mem.mem_addr_o = base_reg + ADDR_W'(idx_reg);
        wr_pend_next   = 1'b1;
        wr_idx_next    = idx_reg;
        if (idx_reg == LAST_IDX) begin
          idx_next   = '0;
          state_next = LOAD_FLUSH;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      LOAD_FLUSH: begin
        busy_o     = 1'b1;
        state_next = DONE;
      end
      STORE: begin
        busy_o          = 1'b1;
        mem.mem_wr_o    = 1'b1;
        mem.mem_addr_o  = base_reg + ADDR_W'(idx_reg);
        mem.mem_wdata_o = rows[idx_reg];
        if (idx_reg == LAST_IDX) begin
          idx_next   = '0;
          state_next = DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  for (genvar gi = 0; gi < NUM_CLAUSES; gi++) begin : g_wr
    assign wr_o[gi] = wr_pend_reg && (wr_idx_reg == IDX_W'(gi));
  end

  assign lit_o = wr_pend_reg ? clean_word : '0;
  assign err_o = err_reg;

endmodule
